adc_pair_sequencer: RTL and testbench
=====================================

// Module: adc_pair_sequencer
// PURPOSE
// - Control stage wrapped around ADC_fp. It drives ADC_SEL, ADC_EN and REG_RST, and consumes ADC_DONE and ADC_16Q48_OUT.
// - On START it runs one averaged conversion on channel A, then one on channel B.
// - It latches both 16Q48 results, forms the saturated difference A-B, and hands the set to the SPGD update logic with a one-cycle VALID.
// PARAMETERS
// - FP_WIDTH       64      width of 16Q48 results; must match ADC_fp
// - SETTLE_CYCLES  16      cycles to wait after ADC_SEL changes, before ADC_EN rises (>=1)
// - TIMEOUT_CYCLES 8192    cycles allowed in ACQ for ADC_DONE before abort (> ADC_fp NUM_SAMPS)
// - CNT_WIDTH      14      counter width; must satisfy 2**CNT_WIDTH > max(SETTLE_CYCLES, TIMEOUT_CYCLES)
// PORTS
// - ADC_CLK        in   1         single clock, same domain as ADC_fp
// - RST_N          in   1         asynchronous active-low reset
// - START          in   1         request a measurement pair; sampled only in IDLE
// - ABORT          in   1         synchronous cancel; returns to IDLE next cycle
// - ADC_DONE       in   1         1-cycle pulse from ADC_fp when an average completes
// - ADC_16Q48_IN   in   FP_WIDTH  ADC_fp result (signed 16Q48)
// - ADC_SEL        out  1         0 = channel A, 1 = channel B
// - ADC_EN         out  1         averaging enable to ADC_fp
// - REG_RST        out  1         active-high clear pulse to the ADC_fp average register
// - BUSY           out  1         high in every state except IDLE
// - VALID          out  1         1-cycle pulse; META_A/META_B/DIFF are stable from this cycle on
// - ERR            out  1         sticky timeout flag; cleared by the next accepted START
// - META_A         out  FP_WIDTH  latched channel A result
// - META_B         out  FP_WIDTH  latched channel B result
// - DIFF           out  FP_WIDTH  sat(META_A - META_B), signed 16Q48
// BEHAVIOUR
// - Reset (RST_N=0, async): state=IDLE; all outputs 0, except REG_RST=1 while in reset.
// - States: IDLE, CLR, SETTLE, ACQ, WAITREG, CAPT, CALC.
//   - IDLE:    START=1 -> CLR. Clears ERR; ch<=A.
//   - CLR:     one cycle; REG_RST=1; ADC_SEL=ch. -> SETTLE.
//   - SETTLE:  count SETTLE_CYCLES with ADC_EN=0. -> ACQ.
//   - ACQ:     ADC_EN=1; timeout counter runs.
//              ADC_DONE=1 -> WAITREG.
//              Counter reaches TIMEOUT_CYCLES -> IDLE with ERR=1 and no VALID.
//   - WAITREG: one cycle with ADC_EN=0, covering the ADC_fp register write plus multiply path.
//   - CAPT:    latch ADC_16Q48_IN into META_A (ch=A) or META_B (ch=B).
//              ch=A -> set ch=B, go to CLR. ch=B -> CALC.
//   - CALC:    DIFF <= saturated difference; VALID=1 for this one cycle. -> IDLE.
// - ADC_SEL holds its value from CLR through CAPT. It never changes while ADC_EN=1.
// - Latency: START to VALID = 2*(1 + SETTLE_CYCLES + N_acq + 2) + 1 cycles. N_acq is the cycle count from ADC_EN rising to ADC_DONE.
// - Arithmetic:
//   - 65-bit signed subtract.
//   - Positive overflow -> 64'h7FFF_FFFF_FFFF_FFFF.
//   - Negative overflow -> 64'h8000_0000_0000_0000.
//   - No rounding.
// - Boundary conditions:
//   - START while BUSY: ignored, not queued.
//   - START and ABORT in the same cycle: ABORT wins.
//   - ABORT in any state: next cycle IDLE, ADC_EN=0, no VALID. META_*/DIFF keep their previous values.
//   - ADC_DONE outside ACQ: ignored.
//   - ADC_DONE on the timeout cycle: DONE wins, no ERR.
//   - Reset mid-operation: immediate IDLE; META_*, DIFF and ERR are cleared.
//   - VALID and ERR are never set for the same START.
// - Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package (spgd_pkg): state encoding constants, FP_WIDTH, SAT_POS/SAT_NEG constants for 16Q48.
// - One sub-module: fp_sat_sub (combinational saturating subtractor, reused by the SPGD update stage).
// - FSM, counter and result registers are inline in this module.
// - Top-level usage: instantiate next to ADC_fp.
//   - ADC_fp.ADC_DONE -> ADC_DONE; ADC_fp.ADC_16Q48_OUT -> ADC_16Q48_IN.
//   - ADC_SEL, ADC_EN and REG_RST drive the ADC_fp inputs of the same names.
// TESTING
// - Nominal pair:
//   - Stimulus: behavioural ADC_fp model returns 64'h0001_0000_0000_0000 (A) and 64'h0000_8000_0000_0000 (B).
//   - Required: META_A/META_B equal those values; DIFF=64'h0000_8000_0000_0000; exactly one VALID; cycle count per latency formula.
// - Saturation:
//   - A=64'h7FFF_0000_0000_0000, B=64'h8001_0000_0000_0000 -> DIFF=64'h7FFF_FFFF_FFFF_FFFF.
//   - Swap A and B -> DIFF=64'h8000_0000_0000_0000.
// - Timeout:
//   - ADC_DONE never pulses -> after TIMEOUT_CYCLES in ACQ: ERR=1, BUSY=0, no VALID.
//   - Next START clears ERR.
// - Abort/start rules:
//   - ABORT during channel-B SETTLE -> IDLE next cycle, META_A updated, META_B unchanged, no VALID.
//   - START pulsed while BUSY -> no second sequence.
// - Mux safety: assertion that ADC_SEL never toggles while ADC_EN=1, and that REG_RST pulses exactly once per channel.
// - Reset: RST_N low mid-ACQ -> all outputs 0 asynchronously (REG_RST=1 during reset); a fresh START after release completes normally.

Source files
------------

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD measurement path.
//   - FSM state encodings for adc_pair_sequencer
//   - default 16Q48 word width and its saturation limits
package spgd_pkg;

  localparam int SPGD_FP_WIDTH = 64;

  localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_ACQ     = 3'd3;
  localparam logic [2:0] S_WAITREG = 3'd4;
  localparam logic [2:0] S_CAPT    = 3'd5;
  localparam logic [2:0] S_CALC    = 3'd6;

endpackage

// File: rtl/fp_sat_sub.sv
// Combinational saturating subtractor for signed fixed-point words.
//   a_i : minuend   (signed, W bits)
//   b_i : subtrahend (signed, W bits)
//   y_o : a_i - b_i clamped to the signed W-bit range, no rounding
module fp_sat_sub
  import spgd_pkg::*;
#(
  parameter int W = SPGD_FP_WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [W:0] d;

  // One guard bit: the W+1-bit result is exact, and overflow shows up as the
  // top two bits disagreeing. The guard bit then gives the true sign.
  assign d = {a_i[W-1], a_i} - {b_i[W-1], b_i};

  always_comb begin
    y_o = d[W-1:0];
    if (d[W] != d[W-1])
      y_o = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/adc_pair_sequencer.sv
// Sequencer around ADC_fp. It takes one averaged sample on channel A, then one
// on channel B, and presents A, B and the saturated A-B with a one-cycle VALID.
//   ADC_CLK, RST_N      : clock, async active-low reset
//   START, ABORT        : request a pair (sampled in IDLE) / cancel from any state
//   ADC_DONE            : average-complete pulse from ADC_fp
//   ADC_16Q48_IN        : ADC_fp result
//   ADC_SEL/ADC_EN      : channel mux select and averaging enable to ADC_fp
//   REG_RST             : clear of the ADC_fp average register
//   BUSY/VALID/ERR      : status; ERR is a sticky acquisition timeout
//   META_A/META_B/DIFF  : latched results
module adc_pair_sequencer
  import spgd_pkg::*;
#(
  parameter int FP_WIDTH       = SPGD_FP_WIDTH,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int CNT_WIDTH      = 14
) (
  input  logic                ADC_CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                ABORT,
  input  logic                ADC_DONE,
  input  logic [FP_WIDTH-1:0] ADC_16Q48_IN,
  output logic                ADC_SEL,
  output logic                ADC_EN,
  output logic                REG_RST,
  output logic                BUSY,
  output logic                VALID,
  output logic                ERR,
  output logic [FP_WIDTH-1:0] META_A,
  output logic [FP_WIDTH-1:0] META_B,
  output logic [FP_WIDTH-1:0] DIFF
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic                 ch_q, ch_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [FP_WIDTH-1:0]  meta_a_q, meta_a_d;
  logic [FP_WIDTH-1:0]  meta_b_q, meta_b_d;
  logic [FP_WIDTH-1:0]  diff_q, diff_d;
  logic                 rst_hold_q;
  logic [FP_WIDTH-1:0]  sub_y;

  // Difference is taken against the live ADC word while channel B is being
  // captured, so DIFF is already registered in the VALID cycle.
  fp_sat_sub #(.W(FP_WIDTH)) u_sub (
    .a_i (meta_a_q),
    .b_i (ADC_16Q48_IN),
    .y_o (sub_y)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = '0;
    err_d    = err_q;
    meta_a_d = meta_a_q;
    meta_b_d = meta_b_q;
    diff_d   = diff_q;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          state_d = S_CLR;
          err_d   = 1'b0;
          ch_d    = 1'b0;
        end
        S_CLR: state_d = S_SETTLE;
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = S_ACQ;
          else                      cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
        S_ACQ: begin
          // DONE is checked first so it wins on the last timeout cycle.
          if (ADC_DONE) begin
            state_d = S_WAITREG;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_WAITREG: state_d = S_CAPT;
        S_CAPT: begin
          if (!ch_q) begin
            meta_a_d = ADC_16Q48_IN;
            ch_d     = 1'b1;
            state_d  = S_CLR;
          end else begin
            meta_b_d = ADC_16Q48_IN;
            diff_d   = sub_y;
            state_d  = S_CALC;
          end
        end
        S_CALC:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ch_q       <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      meta_a_q   <= '0;
      meta_b_q   <= '0;
      diff_q     <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      meta_a_q   <= meta_a_d;
      meta_b_q   <= meta_b_d;
      diff_q     <= diff_d;
      rst_hold_q <= 1'b0;
    end
  end

  // All outputs decode registers only. rst_hold_q keeps the ADC_fp average
  // register cleared for as long as reset is applied.
  assign ADC_SEL = ch_q;
  assign ADC_EN  = (state_q == S_ACQ);
  assign REG_RST = (state_q == S_CLR) | rst_hold_q;
  assign BUSY    = (state_q != S_IDLE);
  assign VALID   = (state_q == S_CALC);
  assign ERR     = err_q;
  assign META_A  = meta_a_q;
  assign META_B  = meta_b_q;
  assign DIFF    = diff_q;

endmodule

// File: tb/tb_adc_pair_sequencer.sv
module tb_adc_pair_sequencer;

  localparam int S    = 4;
  localparam int T    = 40;
  localparam int NACQ = 5;
  localparam int LAT  = 2 * (1 + S + NACQ + 2) + 1;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        ADC_DONE = 1'b0;
  logic [63:0] ADC_16Q48_IN;
  logic        ADC_SEL, ADC_EN, REG_RST, BUSY, VALID, ERR;
  logic [63:0] META_A, META_B, DIFF;

  logic [63:0] val_a = '0, val_b = '0;
  bit          model_on = 1'b1;
  int          en_cnt = 0;
  int          valid_cnt = 0, rr_cnt = 0, sel_viol = 0;
  logic        prev_rr = 1'b0, prev_en = 1'b0, prev_sel = 1'b0;
  int          checks = 0, failures = 0;

  adc_pair_sequencer #(
    .FP_WIDTH(64), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)
  ) dut (
    .ADC_CLK(clk), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .ADC_DONE(ADC_DONE), .ADC_16Q48_IN(ADC_16Q48_IN),
    .ADC_SEL(ADC_SEL), .ADC_EN(ADC_EN), .REG_RST(REG_RST), .BUSY(BUSY),
    .VALID(VALID), .ERR(ERR), .META_A(META_A), .META_B(META_B), .DIFF(DIFF)
  );

  always #5 clk = ~clk;

  // ADC_fp stand-in: muxed result, DONE after NACQ enabled cycles.
  assign ADC_16Q48_IN = ADC_SEL ? val_b : val_a;

  always @(negedge clk) begin
    ADC_DONE = 1'b0;
    if (ADC_EN) begin
      en_cnt = en_cnt + 1;
      if (en_cnt == NACQ && model_on) ADC_DONE = 1'b1;
    end else begin
      en_cnt = 0;
    end
  end

  // Monitors: VALID pulses, REG_RST pulses, mux changes while enabled.
  always @(posedge clk) begin
    if (VALID) valid_cnt <= valid_cnt + 1;
    if (RST_N && REG_RST && !prev_rr) rr_cnt <= rr_cnt + 1;
    if (ADC_EN && prev_en && (ADC_SEL != prev_sel)) sel_viol <= sel_viol + 1;
    prev_rr  <= REG_RST;
    prev_en  <= ADC_EN;
    prev_sel <= ADC_SEL;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse START, then wait (bounded) for VALID; cyc is the cycle VALID shows.
  task automatic run_pair(input logic [63:0] a, input logic [63:0] b, input bit poke,
                          output int cyc, output logic err1);
    val_a = a;
    val_b = b;
    err1  = 1'bx;
    @(negedge clk);
    START = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      START = (poke && cyc == 7);
      cyc++;
      if (cyc == 1) err1 = ERR;
      if (VALID) break;
    end
    START = 1'b0;
  endtask

  initial begin
    int          cyc, v0, r0;
    logic        e1;
    logic [63:0] old_b, old_d;

    // Reset state
    #12;
    chk("rst_regrst", REG_RST, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_en", ADC_EN, 1'b0);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_meta_a", META_A, 64'h0);
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    chk("post_rst_regrst", REG_RST, 1'b0);

    // Nominal pair, with a START poke while busy
    v0 = valid_cnt; r0 = rr_cnt;
    run_pair(64'h0001_0000_0000_0000, 64'h0000_8000_0000_0000, 1'b1, cyc, e1);
    chk("nom_latency", 64'(cyc), 64'(LAT));
    chk("nom_meta_a", META_A, 64'h0001_0000_0000_0000);
    chk("nom_meta_b", META_B, 64'h0000_8000_0000_0000);
    chk("nom_diff", DIFF, 64'h0000_8000_0000_0000);
    @(negedge clk);
    chk("nom_valid_1cyc", VALID, 1'b0);
    repeat (30) @(negedge clk);
    chk("nom_valid_count", 64'(valid_cnt - v0), 64'd1);
    chk("busy_start_ignored", BUSY, 1'b0);
    chk("nom_regrst_pulses", 64'(rr_cnt - r0), 64'd2);

    // Negative, non-saturating result
    run_pair(64'h0000_8000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, cyc, e1);
    chk("neg_diff", DIFF, 64'hFFFF_8000_0000_0000);

    // Saturation both ways
    run_pair(64'h7FFF_0000_0000_0000, 64'h8001_0000_0000_0000, 1'b0, cyc, e1);
    chk("sat_pos", DIFF, 64'h7FFF_FFFF_FFFF_FFFF);
    run_pair(64'h8001_0000_0000_0000, 64'h7FFF_0000_0000_0000, 1'b0, cyc, e1);
    chk("sat_neg", DIFF, 64'h8000_0000_0000_0000);
    chk("sat_neg_meta_b", META_B, 64'h7FFF_0000_0000_0000);
    repeat (2) @(negedge clk);

    // Timeout: DONE never arrives
    model_on = 1'b0;
    v0 = valid_cnt;
    START = 1'b1;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      START = 1'b0;
      cyc++;
      if (!BUSY) break;
    end
    chk("to_cycles", 64'(cyc), 64'(1 + S + T + 1));
    chk("to_err", ERR, 1'b1);
    chk("to_busy", BUSY, 1'b0);
    chk("to_no_valid", 64'(valid_cnt - v0), 64'd0);
    model_on = 1'b1;
    run_pair(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0001, 1'b0, cyc, e1);
    chk("err_cleared_by_start", e1, 1'b0);
    chk("after_to_diff", DIFF, 64'h0000_0000_0000_0002);
    repeat (2) @(negedge clk);

    // START and ABORT together: ABORT wins
    START = 1'b1; ABORT = 1'b1;
    @(negedge clk);
    START = 1'b0; ABORT = 1'b0;
    chk("start_abort_idle", BUSY, 1'b0);

    // ABORT during channel-B SETTLE
    old_b = META_B; old_d = DIFF; v0 = valid_cnt;
    val_a = 64'h0000_1234_0000_0000;
    val_b = 64'h0000_0000_5678_0000;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (REG_RST && ADC_SEL) break;
      @(negedge clk);
    end
    @(negedge clk);
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_en", ADC_EN, 1'b0);
    chk("abort_meta_a", META_A, 64'h0000_1234_0000_0000);
    chk("abort_meta_b", META_B, old_b);
    chk("abort_diff", DIFF, old_d);
    repeat (5) @(negedge clk);
    chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);

    // Reset mid-ACQ
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ADC_EN) break;
      @(negedge clk);
    end
    chk("reached_acq", ADC_EN, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_busy", BUSY, 1'b0);
    chk("mrst_en", ADC_EN, 1'b0);
    chk("mrst_regrst", REG_RST, 1'b1);
    chk("mrst_meta_a", META_A, 64'h0);
    chk("mrst_diff", DIFF, 64'h0);
    chk("mrst_sel", ADC_SEL, 1'b0);
    @(negedge clk);
    RST_N = 1'b1;
    run_pair(64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 1'b0, cyc, e1);
    chk("fresh_latency", 64'(cyc), 64'(LAT));
    chk("fresh_diff", DIFF, 64'hFFFF_FFFF_0000_0000);
    repeat (2) @(negedge clk);

    chk("sel_stable_while_en", 64'(sel_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
